// File: rtl/switch_debouncer_pkg.sv
// led_blinker_pkg: shared debouncer state encoding and the default 10 ms window at 25 MHz.
package led_blinker_pkg;
  typedef enum logic {STABLE, CHANGING} db_state_e;
  localparam int CLOCK_HZ = 25_000_000;
  localparam int DEFAULT_STABLE_COUNT = CLOCK_HZ / 100 - 1;
endpackage

// File: rtl/switch_debouncer_if.sv
// switch_debouncer_if: raw switch levels in, debounced levels, edge pulses and busy out.
interface switch_debouncer_if #(parameter int N_CH = 3);
  logic [N_CH-1:0] i_raw;
  logic [N_CH-1:0] o_clean;
  logic [N_CH-1:0] o_rise;
  logic [N_CH-1:0] o_fall;
  logic            o_busy;
  modport master (output i_raw, input o_clean, o_rise, o_fall, o_busy);
  modport slave  (input i_raw, output o_clean, o_rise, o_fall, o_busy);
endinterface

// File: rtl/switch_debouncer_channel.sv
// debounce_channel: one-bit synchroniser, stability counter and STABLE/CHANGING FSM.
// Edge pulse registers exist only when SWITCH_DEBOUNCE_EDGE_EN is defined.
module debounce_channel
  import led_blinker_pkg::*;
#(
  parameter int STABLE_COUNT = DEFAULT_STABLE_COUNT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_raw,
  output logic o_clean,
  output logic o_rise,
  output logic o_fall,
  output logic o_busy
);
  localparam int CW = $clog2(STABLE_COUNT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STABLE_COUNT);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          count_q;
  db_state_e              state_q;
  logic                   clean_q;
  logic                   sync;
  assign sync = sync_q[SYNC_STAGES-1];
  always_ff @(posedge i_clock or negedge i_reset_n)
    if (!i_reset_n) sync_q <= '0;
    else sync_q <= {sync_q[SYNC_STAGES-2:0], i_raw};
  // A bounce back to the old level takes priority over acceptance.
  always_ff @(posedge i_clock or negedge i_reset_n)
    if (!i_reset_n) begin
      state_q <= STABLE;
      count_q <= '0;
      clean_q <= 1'b0;
    end else begin
      case (state_q)
        STABLE: begin
          count_q <= '0;
          if (sync != clean_q) state_q <= CHANGING;
        end
        CHANGING:
          if (sync == clean_q) begin
            state_q <= STABLE;
            count_q <= '0;
          end else if (count_q == LIMIT) begin
            clean_q <= sync;
            state_q <= STABLE;
            count_q <= '0;
          end else count_q <= count_q + 1'b1;
        default: state_q <= STABLE;
      endcase
    end
`ifdef SWITCH_DEBOUNCE_EDGE_EN
  logic rise_q, fall_q, accept;
  assign accept = state_q == CHANGING && sync != clean_q && count_q == LIMIT;
  always_ff @(posedge i_clock or negedge i_reset_n)
    if (!i_reset_n) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= accept & sync;
      fall_q <= accept & ~sync;
    end
  assign o_rise = rise_q;
  assign o_fall = fall_q;
`else
  assign o_rise = 1'b0;
  assign o_fall = 1'b0;
`endif
  assign o_clean = clean_q;
  assign o_busy  = state_q == CHANGING;
endmodule

// File: rtl/switch_debouncer.sv
// switch_debouncer: N_CH independent debounce channels with a shared busy flag.
// Edge pulses are built when SWITCH_DEBOUNCE_EDGE_EN is defined, otherwise tied to 0.
module switch_debouncer
  import led_blinker_pkg::*;
#(
  parameter int N_CH         = 3,
  parameter int STABLE_COUNT = DEFAULT_STABLE_COUNT,
  parameter int SYNC_STAGES  = 2
) (
  input logic i_clock,
  input logic i_reset_n,
  switch_debouncer_if.slave sw
);
  logic [N_CH-1:0] busy;
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    debounce_channel #(.STABLE_COUNT(STABLE_COUNT), .SYNC_STAGES(SYNC_STAGES)) u_ch (
      .i_clock  (i_clock),
      .i_reset_n(i_reset_n),
      .i_raw    (sw.i_raw[c]),
      .o_clean  (sw.o_clean[c]),
      .o_rise   (sw.o_rise[c]),
      .o_fall   (sw.o_fall[c]),
      .o_busy   (busy[c])
    );
  end
  assign sw.o_busy = |busy;
endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer: directed checks with STABLE_COUNT=7, SYNC_STAGES=2 (latency 10 edges).
module tb_switch_debouncer;
`ifdef SWITCH_DEBOUNCE_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif
  logic i_clock = 1'b0;
  logic i_reset_n = 1'b0;
  int n_checks = 0;
  int n_err = 0;
  int rise_cnt[3] = '{0, 0, 0};
  int fall_cnt[3] = '{0, 0, 0};
  int rise_base[3];
  int fall_base[3];
  logic busy_seen;
  switch_debouncer_if #(.N_CH(3)) sw ();
  switch_debouncer #(.N_CH(3), .STABLE_COUNT(7), .SYNC_STAGES(2)) dut (
    .i_clock  (i_clock),
    .i_reset_n(i_reset_n),
    .sw       (sw.slave)
  );
  always #5 i_clock = ~i_clock;
  always @(negedge i_clock)
    for (int c = 0; c < 3; c++) begin
      if (sw.o_rise[c]) rise_cnt[c]++;
      if (sw.o_fall[c]) fall_cnt[c]++;
    end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge i_clock);
    #1;
  endtask
  task automatic snap();
    for (int c = 0; c < 3; c++) begin
      rise_base[c] = rise_cnt[c];
      fall_base[c] = fall_cnt[c];
    end
  endtask
  initial begin
    sw.i_raw = 3'b000;
    step(3);
    check("rst_clean", 32'(sw.o_clean), 0);
    check("rst_busy", 32'(sw.o_busy), 0);
    check("rst_rise", 32'(sw.o_rise), 0);
    check("rst_fall", 32'(sw.o_fall), 0);
    i_reset_n = 1'b1;
    busy_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      busy_seen |= sw.o_busy;
    end
    check("idle_busy", 32'(busy_seen), 0);
    check("idle_clean", 32'(sw.o_clean), 0);
    snap();
    sw.i_raw = 3'b001;
    step(1);
    step(1);
    check("rise_busy_k1", 32'(sw.o_busy), 0);
    step(1);
    check("rise_busy_k2", 32'(sw.o_busy), 1);
    step(7);
    check("rise_clean_k9", 32'(sw.o_clean), 3'b000);
    step(1);
    check("rise_clean_k10", 32'(sw.o_clean), 3'b001);
    check("rise_pulse_k10", 32'(sw.o_rise), EDGE ? 3'b001 : 3'b000);
    check("rise_busy_k10", 32'(sw.o_busy), 0);
    step(1);
    check("rise_pulse_k11", 32'(sw.o_rise), 0);
    check("rise_count0", 32'(rise_cnt[0] - rise_base[0]), EDGE ? 1 : 0);
    snap();
    for (int i = 0; i < 4; i++) begin
      sw.i_raw[1] = ~i[0];
      step(3);
    end
    check("bounce_clean_mid", 32'(sw.o_clean), 3'b001);
    sw.i_raw[1] = 1'b1;
    step(10);
    check("bounce_clean_k9", 32'(sw.o_clean), 3'b001);
    step(1);
    check("bounce_clean_k10", 32'(sw.o_clean), 3'b011);
    step(2);
    check("bounce_rise1", 32'(rise_cnt[1] - rise_base[1]), EDGE ? 1 : 0);
    check("bounce_fall1", 32'(fall_cnt[1] - fall_base[1]), 0);
    snap();
    sw.i_raw[2] = 1'b1;
    step(5);
    sw.i_raw[2] = 1'b0;
    step(20);
    check("glitch_clean", 32'(sw.o_clean), 3'b011);
    check("glitch_rise2", 32'(rise_cnt[2] - rise_base[2]), 0);
    check("glitch_fall2", 32'(fall_cnt[2] - fall_base[2]), 0);
    check("glitch_busy", 32'(sw.o_busy), 0);
    snap();
    sw.i_raw = 3'b000;
    step(15);
    check("fall_clean", 32'(sw.o_clean), 3'b000);
    check("fall_cnt0", 32'(fall_cnt[0] - fall_base[0]), EDGE ? 1 : 0);
    check("fall_cnt1", 32'(fall_cnt[1] - fall_base[1]), EDGE ? 1 : 0);
    check("fall_cnt2", 32'(fall_cnt[2] - fall_base[2]), 0);
    sw.i_raw = 3'b111;
    step(10);
    check("sim_clean_k9", 32'(sw.o_clean), 3'b000);
    check("sim_busy_k9", 32'(sw.o_busy), 1);
    step(1);
    check("sim_clean_k10", 32'(sw.o_clean), 3'b111);
    check("sim_rise_k10", 32'(sw.o_rise), EDGE ? 3'b111 : 3'b000);
    check("sim_fall_k10", 32'(sw.o_fall), 0);
    step(1);
    check("sim_rise_k11", 32'(sw.o_rise), 0);
    step(3);
    snap();
    sw.i_raw = 3'b000;
    step(7);
    check("abort_busy_pre", 32'(sw.o_busy), 1);
    i_reset_n = 1'b0;
    #1;
    check("abort_clean", 32'(sw.o_clean), 0);
    check("abort_busy", 32'(sw.o_busy), 0);
    check("abort_rise", 32'(sw.o_rise), 0);
    check("abort_fall", 32'(sw.o_fall), 0);
    step(3);
    i_reset_n = 1'b1;
    step(20);
    check("abort_clean_post", 32'(sw.o_clean), 0);
    check("abort_busy_post", 32'(sw.o_busy), 0);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("abort_fall%0d", c), 32'(fall_cnt[c] - fall_base[c]), 0);
      check($sformatf("abort_rise%0d", c), 32'(rise_cnt[c] - rise_base[c]), 0);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
